lna_array_emu: RTL and testbench

- Parametrised, clocked successor to the single-bit LNA switch emulator.
- Models NCH independent LNA channels. Each channel carries signed DATA_W-bit baseband samples and has:
  - a power-down/settle state machine,
  - a mode-dependent digital gain with saturation,
  - a sticky non-default-mode warning flag.
- Sits between the antenna/channel model and the mixer/ADC emulation in the radio front-end testbench/SoC model.

---
 rtl/lna_pkg.sv | 40 ++++
 rtl/lna_emu_ch.sv | 101 ++++++++++
 rtl/lna_array_emu.sv | 44 ++++
 tb/tb_lna_array_emu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lna_pkg.sv
// Shared types, gain-mode encodings and the saturating gain helper
// for the multi-channel LNA emulator.
package lna_pkg;

  typedef enum logic [1:0] {
    LNA_OFF    = 2'd0,
    LNA_SETTLE = 2'd1,
    LNA_ON     = 2'd2
  } lna_state_t;

  localparam logic [1:0] LNA_MODE_LOW  = 2'b00;
  localparam logic [1:0] LNA_MODE_DEF  = 2'b01;
  localparam logic [1:0] LNA_MODE_HIGH = 2'b10;
  localparam logic [1:0] LNA_MODE_RSVD = 2'b11;

  // Sample is passed sign-extended to 32 bits; data_w sets the saturation
  // range, and the caller truncates the result back to data_w bits.
  function automatic logic signed [31:0] lna_gain(
    input logic signed [31:0] sample,
    input logic        [1:0]  mode,
    input int unsigned        data_w
  );
    logic signed [31:0] maxv;
    logic signed [31:0] minv;
    logic signed [31:0] dbl;
    maxv = (32'sd1 <<< (data_w - 1)) - 32'sd1;
    minv = -maxv - 32'sd1;
    dbl  = sample <<< 1;
    case (mode)
      LNA_MODE_LOW:  lna_gain = sample >>> 1;
      LNA_MODE_HIGH: begin
        if (dbl > maxv)      lna_gain = maxv;
        else if (dbl < minv) lna_gain = minv;
        else                 lna_gain = dbl;
      end
      default:       lna_gain = sample;
    endcase
  endfunction

endpackage

// File: rtl/lna_emu_ch.sv
// One LNA channel: power-down/settle FSM, mode register, gained output
// register and sticky mode warning/error flags.
module lna_emu_ch
  import lna_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned MODE_CYC   = 4,
  parameter logic [1:0]  DEF_MODE   = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] signal_in,
  input  logic              lna_pd,
  input  logic [1:0]        lna_mode,
  input  logic              warn_clr,
  output logic [DATA_W-1:0] signal_out,
  output logic              lna_ready,
  output logic              mode_warn,
  output logic              mode_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > MODE_CYC) ? SETTLE_CYC : MODE_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  lna_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              warn_q, warn_d;
  logic              err_q, err_d;
  logic              active;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      LNA_OFF: begin
        if (!lna_pd) begin
          state_d = LNA_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          mode_d  = lna_mode;
        end
      end
      LNA_SETTLE: begin
        if (lna_pd) begin
          state_d = LNA_OFF;
        end else begin
          // Mode may still move while settling; the counter keeps running.
          mode_d = lna_mode;
          if (cnt_q == '0) state_d = LNA_ON;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      LNA_ON: begin
        if (lna_pd) begin
          state_d = LNA_OFF;
        end else if (lna_mode != mode_q) begin
          state_d = LNA_SETTLE;
          cnt_d   = CNT_W'(MODE_CYC - 1);
          mode_d  = lna_mode;
        end
      end
      default: state_d = LNA_OFF;
    endcase

    out_d = '0;
    if (state_d == LNA_ON)
      out_d = DATA_W'(lna_gain(32'(signed'(signal_in)), mode_d, DATA_W));

    // Set dominates clear when both happen in the same cycle.
    active = (state_q != LNA_OFF);
    warn_d = (active && (lna_mode != DEF_MODE))      || (warn_q && !warn_clr);
    err_d  = (active && (lna_mode == LNA_MODE_RSVD)) || (err_q  && !warn_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LNA_OFF;
      cnt_q   <= '0;
      mode_q  <= '0;
      out_q   <= '0;
      warn_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      warn_q  <= warn_d;
      err_q   <= err_d;
    end
  end

  assign signal_out = out_q;
  assign lna_ready  = (state_q == LNA_ON);
  assign mode_warn  = warn_q;
  assign mode_err   = err_q;

endmodule

// File: rtl/lna_array_emu.sv
// NCH-channel LNA switch emulator: independent channels sharing only
// the clock, reset and the global flag clear.
module lna_array_emu
  import lna_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned MODE_CYC   = 4,
  parameter logic [1:0]  DEF_MODE   = LNA_MODE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*DATA_W-1:0] signal_in,
  input  logic [NCH-1:0]        lna_pd,
  input  logic [2*NCH-1:0]      lna_mode,
  input  logic                  warn_clr,
  output logic [NCH*DATA_W-1:0] signal_out,
  output logic [NCH-1:0]        lna_ready,
  output logic [NCH-1:0]        mode_warn,
  output logic [NCH-1:0]        mode_err
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    lna_emu_ch #(
      .DATA_W    (DATA_W),
      .SETTLE_CYC(SETTLE_CYC),
      .MODE_CYC  (MODE_CYC),
      .DEF_MODE  (DEF_MODE)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .signal_in (signal_in[k*DATA_W +: DATA_W]),
      .lna_pd    (lna_pd[k]),
      .lna_mode  (lna_mode[2*k +: 2]),
      .warn_clr  (warn_clr),
      .signal_out(signal_out[k*DATA_W +: DATA_W]),
      .lna_ready (lna_ready[k]),
      .mode_warn (mode_warn[k]),
      .mode_err  (mode_err[k])
    );
  end

endmodule

// File: tb/tb_lna_array_emu.sv
// Directed bench for lna_array_emu: gain vector table plus hand-written
// power-up, mode-change, power-down, flag and async-reset sequences.
module tb_lna_array_emu;

  localparam int NCH    = 2;
  localparam int DATA_W = 12;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NCH*DATA_W-1:0] signal_in;
  logic [NCH-1:0]        lna_pd;
  logic [2*NCH-1:0]      lna_mode;
  logic                  warn_clr;
  logic [NCH*DATA_W-1:0] signal_out;
  logic [NCH-1:0]        lna_ready;
  logic [NCH-1:0]        mode_warn;
  logic [NCH-1:0]        mode_err;

  int n_chk  = 0;
  int n_fail = 0;

  lna_array_emu #(
    .NCH       (NCH),
    .DATA_W    (DATA_W),
    .SETTLE_CYC(16),
    .MODE_CYC  (4),
    .DEF_MODE  (2'b01)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .signal_in (signal_in),
    .lna_pd    (lna_pd),
    .lna_mode  (lna_mode),
    .warn_clr  (warn_clr),
    .signal_out(signal_out),
    .lna_ready (lna_ready),
    .mode_warn (mode_warn),
    .mode_err  (mode_err)
  );

  always #5 clk = ~clk;

  logic [NCH-1:0] warn_prev = '0;
  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++)
      if (mode_warn[k] && !warn_prev[k]) $display("note: mode_warn[%0d] rose at %0t", k, $time);
    warn_prev <= mode_warn;
  end

  typedef struct {
    logic [1:0] mode;
    int         sample;
    int         exp;
  } vec_t;

  vec_t vecs[13];

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int out_ch(input int k);
    logic [DATA_W-1:0] s;
    s = signal_out[k*DATA_W +: DATA_W];
    return int'($signed(s));
  endfunction

  task automatic set_in0(input int v);
    signal_in[DATA_W-1:0] = DATA_W'(v);
  endtask

  // Steps n edges; ready[0] must stay low for the first n-1 and be high after the n-th.
  task automatic wait_ready_exact(input string name, input int n);
    int first;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (lna_ready[0] && first < 0) first = i;
    end
    chk(name, first, n);
  endtask

  initial begin
    vecs[0]  = '{2'b01,   100,   100};
    vecs[1]  = '{2'b01,  -100,  -100};
    vecs[2]  = '{2'b10,  1500,  2047};
    vecs[3]  = '{2'b10, -1500, -2048};
    vecs[4]  = '{2'b10,   300,   600};
    vecs[5]  = '{2'b10,  1023,  2046};
    vecs[6]  = '{2'b10,  1024,  2047};
    vecs[7]  = '{2'b10, -1024, -2048};
    vecs[8]  = '{2'b10, -1025, -2048};
    vecs[9]  = '{2'b00,    -7,    -4};
    vecs[10] = '{2'b00,     7,     3};
    vecs[11] = '{2'b00,    -1,    -1};
    vecs[12] = '{2'b01,  2047,  2047};

    rst_n     = 1'b0;
    lna_pd    = '1;
    lna_mode  = 4'b0101;
    warn_clr  = 1'b0;
    signal_in = '0;
    set_in0(100);
    #1;
    chk("reset_out",   int'(signal_out), 0);
    chk("reset_ready", int'(lna_ready), 0);
    chk("reset_flags", int'({mode_warn, mode_err}), 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("off_ready", int'(lna_ready), 0);

    // power-up of ch0
    lna_pd[0] = 1'b0;
    wait_ready_exact("powerup_17", 17);
    chk("powerup_out", out_ch(0), 100);
    set_in0(200);
    step();
    chk("latency_out", out_ch(0), 200);
    chk("ch1_ready", int'(lna_ready[1]), 0);
    chk("ch1_out", out_ch(1), 0);

    // gain table
    begin
      logic [1:0] cur;
      cur = 2'b01;
      foreach (vecs[i]) begin
        if (vecs[i].mode != cur) begin
          cur = vecs[i].mode;
          lna_mode[1:0] = cur;
          step(6);
        end
        set_in0(vecs[i].sample);
        step();
        chk($sformatf("vec%0d_ready", i), int'(lna_ready[0]), 1);
        chk($sformatf("vec%0d_out", i), out_ch(0), vecs[i].exp);
      end
    end
    chk("gain_warn", int'(mode_warn[0]), 1);
    chk("gain_err", int'(mode_err[0]), 0);

    // mode change while ON: 01 -> 00
    set_in0(400);
    lna_mode[1:0] = 2'b00;
    begin
      int bad;
      bad = 0;
      for (int i = 1; i <= 4; i++) begin
        step();
        if (lna_ready[0] || out_ch(0) != 0) bad++;
      end
      chk("modechg_quiet", bad, 0);
    end
    step();
    chk("modechg_ready", int'(lna_ready[0]), 1);
    chk("modechg_out", out_ch(0), 200);

    // power-down has priority over a mode change
    lna_pd[0] = 1'b1;
    lna_mode[1:0] = 2'b10;
    step();
    chk("pd_ready", int'(lna_ready[0]), 0);
    chk("pd_out", out_ch(0), 0);
    lna_mode[1:0] = 2'b01;
    step(20);
    chk("pd_stays_off", int'(lna_ready[0]), 0);

    // flags
    lna_pd[0] = 1'b0;
    wait_ready_exact("repower_17", 17);
    warn_clr = 1'b1;
    step();
    warn_clr = 1'b0;
    chk("clr_warn", int'(mode_warn[0]), 0);
    lna_mode[1:0] = 2'b11;
    step();
    chk("rsvd_warn", int'(mode_warn[0]), 1);
    chk("rsvd_err", int'(mode_err[0]), 1);
    warn_clr = 1'b1;
    step();
    warn_clr = 1'b0;
    chk("setwins_warn", int'(mode_warn[0]), 1);
    chk("setwins_err", int'(mode_err[0]), 1);
    lna_mode[1:0] = 2'b01;
    step();
    warn_clr = 1'b1;
    step();
    warn_clr = 1'b0;
    chk("clr2_flags", int'({mode_warn[0], mode_err[0]}), 0);
    lna_mode[3:2] = 2'b11;
    step(4);
    chk("off_flags_ch1", int'({mode_warn[1], mode_err[1]}), 0);
    lna_mode[3:2] = 2'b01;

    // async reset mid-settle (counter at 7 after 9 edges)
    lna_pd[0] = 1'b1;
    step(2);
    lna_mode[1:0] = 2'b10;
    lna_pd[0] = 1'b0;
    step(9);
    chk("settle_warn", int'(mode_warn[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", int'(signal_out), 0);
    chk("arst_ready", int'(lna_ready), 0);
    chk("arst_flags", int'({mode_warn, mode_err}), 0);
    lna_pd[0] = 1'b1;
    lna_mode[1:0] = 2'b01;
    #1;
    rst_n = 1'b1;
    step(20);
    chk("post_arst_off", int'(lna_ready[0]), 0);
    lna_pd[0] = 1'b0;
    wait_ready_exact("post_arst_17", 17);
    set_in0(-50);
    step();
    chk("post_arst_out", out_ch(0), -50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
